// File: rtl/l2_req_arbiter_if.sv
// L1/L2/memory handshake bundle for l2_req_arbiter.
// slave = arbiter side, master = requesters plus L2 array and memory.
interface l2_req_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
);
  logic [1:0]        req_to_l2;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        ack_to_l1;
  logic [ADDR_W-1:0] addr_tag;
  logic [LINE_W-1:0] data;
  logic              err_to_l1;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_ack;
  logic              l2_hit;
  logic [LINE_W-1:0] l2_data;
  logic              l2_fill;
  logic [LINE_W-1:0] fill_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_data;

  modport slave (
    input  req_to_l2, addr0, addr1, l2_ack, l2_hit, l2_data, mem_ack, mem_data,
    output ack_to_l1, addr_tag, data, err_to_l1, l2_req, l2_addr, l2_fill,
           fill_data, mem_req, mem_addr
  );

  modport master (
    output req_to_l2, addr0, addr1, l2_ack, l2_hit, l2_data, mem_ack, mem_data,
    input  ack_to_l1, addr_tag, data, err_to_l1, l2_req, l2_addr, l2_fill,
           fill_data, mem_req, mem_addr
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// Two-requester round-robin L2 sequencer: lookup, miss fetch, fill, return; one txn in flight.
// Optional memory-wait timeout enabled by defining L2_ARB_TIMEOUT_EN.
module l2_req_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int LINE_W         = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_rst,
  l2_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rr, w_rr_nxt;
  logic              r_owner, w_owner_nxt;
  logic              w_grant;
  logic [1:0]        r_ack, w_ack_nxt;
  logic              r_fill, w_fill_nxt;
  logic              r_l2_req, w_l2_req_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LINE_W-1:0] r_data, w_data_nxt;
  logic [LINE_W-1:0] r_fill_data, w_fill_data_nxt;

`ifdef L2_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_ack       <= 2'b00;
      r_fill      <= 1'b0;
      r_l2_req    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_fill_data <= '0;
`ifdef L2_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rr        <= w_rr_nxt;
      r_owner     <= w_owner_nxt;
      r_ack       <= w_ack_nxt;
      r_fill      <= w_fill_nxt;
      r_l2_req    <= w_l2_req_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_fill_data <= w_fill_data_nxt;
`ifdef L2_ARB_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  // Next-state logic computes the next value of every output register.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr;
    w_owner_nxt     = r_owner;
    w_ack_nxt       = r_ack;
    w_fill_nxt      = r_fill;
    w_l2_req_nxt    = r_l2_req;
    w_mem_req_nxt   = r_mem_req;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_fill_data_nxt = r_fill_data;
`ifdef L2_ARB_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;
`endif
    w_grant = (bus.req_to_l2 == 2'b11) ? r_rr : bus.req_to_l2[1];

    case (r_state)
      IDLE: begin
        if (|bus.req_to_l2) begin
          w_owner_nxt  = w_grant;
          w_addr_nxt   = w_grant ? bus.addr1 : bus.addr0;
          w_l2_req_nxt = 1'b1;
          w_state_nxt  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.l2_ack) begin
          w_l2_req_nxt = 1'b0;
          if (bus.l2_hit) begin
            w_data_nxt  = bus.l2_data;
            w_ack_nxt   = {r_owner, ~r_owner};
            w_state_nxt = RESP;
          end else begin
            w_mem_req_nxt = 1'b1;
`ifdef L2_ARB_TIMEOUT_EN
            w_cnt_nxt     = '0;
`endif
            w_state_nxt   = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          w_mem_req_nxt   = 1'b0;
          w_data_nxt      = bus.mem_data;
          w_fill_data_nxt = bus.mem_data;
          w_fill_nxt      = 1'b1;
          w_ack_nxt       = {r_owner, ~r_owner};
          w_state_nxt     = RESP;
        end
`ifdef L2_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_mem_req_nxt = 1'b0;
          w_data_nxt    = '0;
          w_err_nxt     = 1'b1;
          w_ack_nxt     = {r_owner, ~r_owner};
          w_state_nxt   = RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        w_ack_nxt   = 2'b00;
        w_fill_nxt  = 1'b0;
`ifdef L2_ARB_TIMEOUT_EN
        w_err_nxt   = 1'b0;
`endif
        w_rr_nxt    = ~r_owner;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ack_to_l1 = r_ack;
  assign bus.addr_tag  = r_addr;
  assign bus.l2_addr   = r_addr;
  assign bus.mem_addr  = r_addr;
  assign bus.data      = r_data;
  assign bus.fill_data = r_fill_data;
  assign bus.l2_fill   = r_fill;
  assign bus.l2_req    = r_l2_req;
  assign bus.mem_req   = r_mem_req;
`ifdef L2_ARB_TIMEOUT_EN
  assign bus.err_to_l1 = r_err;
`else
  assign bus.err_to_l1 = 1'b0;
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Scoreboard bench for l2_req_arbiter: directed hit/miss/contention/reset traffic.
module tb_l2_req_arbiter;
  localparam int AW = 16;
  localparam int LW = 256;
`ifdef L2_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_req_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  l2_req_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]    ack;
    logic [AW-1:0] tag;
    logic [LW-1:0] data;
    logic          fill;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic saw_mem = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_req) saw_mem = 1'b1;
    if (!rst) begin
      if (bus.l2_fill && bus.ack_to_l1 == 2'b00) check("fill_without_ack", bus.l2_fill, 0);
      if (bus.ack_to_l1 != 2'b00) begin
        if (sb.size() == 0) check("unexpected_ack", bus.ack_to_l1, 0);
        else begin
          e = sb.pop_front();
          check("ack_onehot", bus.ack_to_l1, e.ack);
          check("addr_tag", bus.addr_tag, e.tag);
          check("data", bus.data, e.data);
          check("l2_fill", bus.l2_fill, e.fill);
          check("err_to_l1", bus.err_to_l1, e.err);
          check("ack_cycle", cyc, e.cyc);
          if (e.fill) check("fill_data", bus.fill_data, e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at the first negedge where the signal is high.
  task automatic wait_for(input int which, output int c);
    for (int i = 0; i < 100; i++) begin
      if ((which == 0 && bus.l2_req) || (which == 1 && bus.mem_req) ||
          (which == 2 && bus.ack_to_l1 != 2'b00)) begin
        c = cyc;
        return;
      end
      @(negedge clk);
    end
    c = -1;
    n_chk++;
    n_fail++;
    $display("FAIL wait_timeout: signal %0d never rose within 100 cycles", which);
  endtask

  // One transaction for an already-requesting owner. mem_lat: MEM_WAIT cycles before mem_ack.
  task automatic run_txn(input int owner, input logic hit, input logic [LW-1:0] d,
                         input int mem_lat, input logic drop);
    int c;
    logic [AW-1:0] tag;
    logic [1:0] ack;
    ack = (owner == 1) ? 2'b10 : 2'b01;
    tag = (owner == 1) ? bus.addr1 : bus.addr0;
    wait_for(0, c);
    check("l2_addr", bus.l2_addr, tag);
    bus.l2_ack  = 1'b1;
    bus.l2_hit  = hit;
    bus.l2_data = hit ? d : ~d;
    if (hit) sb.push_back('{ack, tag, d, 1'b0, 1'b0, c + 1});
    @(negedge clk);
    bus.l2_ack = 1'b0;
    bus.l2_hit = 1'b0;
    if (!hit) begin
      wait_for(1, c);
      check("mem_addr", bus.mem_addr, tag);
      repeat (mem_lat - 1) @(negedge clk);
      bus.mem_ack  = 1'b1;
      bus.mem_data = d;
      sb.push_back('{ack, tag, d, 1'b1, 1'b0, cyc + 1});
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    wait_for(2, c);
    if (drop) bus.req_to_l2[owner] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack"}, bus.ack_to_l1, 0);
    check({tag, "_l2_req"}, bus.l2_req, 0);
    check({tag, "_mem_req"}, bus.mem_req, 0);
    check({tag, "_l2_fill"}, bus.l2_fill, 0);
  endtask

  initial begin
    int c;
    int r;
    logic [LW-1:0] aa, ff55;
    aa   = {32{8'hAA}};
    ff55 = {32{8'h55}};
    bus.req_to_l2 = 2'b00;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.l2_ack = 1'b0;
    bus.l2_hit = 1'b0;
    bus.l2_data = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("rst");
    check("rst_data", bus.data, 0);
    check("rst_fill_data", bus.fill_data, 0);
    check("rst_addr_tag", bus.addr_tag, 0);
    check("rst_err", bus.err_to_l1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("idle");

    // Single hit from requester 0; l2_req must rise one edge after request
    saw_mem = 1'b0;
    bus.addr0 = 16'h1234;
    bus.req_to_l2 = 2'b01;
    r = cyc;
    @(negedge clk);
    wait_for(0, c);
    check("l2_req_latency", c, r + 1);
    run_txn(0, 1'b1, aa, 0, 1'b1);
    check("hit_no_mem_req", saw_mem, 0);

    // Miss from requester 1, mem_ack in 5th MEM_WAIT cycle
    bus.addr1 = 16'h00F0;
    bus.req_to_l2 = 2'b10;
    @(negedge clk);
    run_txn(1, 1'b0, ff55, 5, 1'b1);

    // Contention: both held high, all hits, grant order 0,1,0
    bus.addr0 = 16'h0A00;
    bus.addr1 = 16'h0B01;
    bus.req_to_l2 = 2'b11;
    @(negedge clk);
    run_txn(0, 1'b1, {32{8'h11}}, 0, 1'b0);
    run_txn(1, 1'b1, {32{8'h22}}, 0, 1'b0);
    run_txn(0, 1'b1, {32{8'h33}}, 0, 1'b1);
    bus.req_to_l2 = 2'b00;
    repeat (2) @(negedge clk);
    check_quiet("post_contention");

    // Reset during MEM_WAIT, then a late mem_ack must be ignored
    bus.addr1 = 16'h0C0C;
    bus.req_to_l2 = 2'b10;
    @(negedge clk);
    wait_for(0, c);
    bus.l2_ack = 1'b1;
    bus.l2_hit = 1'b0;
    @(negedge clk);
    bus.l2_ack = 1'b0;
    wait_for(1, c);
    @(negedge clk);
    rst = 1'b1;
    bus.req_to_l2 = 2'b00;
    @(negedge clk);
    check_quiet("midrst");
    check("midrst_data", bus.data, 0);
    check("midrst_fill_data", bus.fill_data, 0);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_data = {32{8'hFF}};
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_quiet("late_mem_ack");
    end

`ifdef L2_ARB_TIMEOUT_EN
    // Timeout: miss with no mem_ack -> err after 4 MEM_WAIT cycles plus RESP
    bus.addr0 = 16'h0D0D;
    bus.req_to_l2 = 2'b01;
    @(negedge clk);
    wait_for(0, c);
    bus.l2_ack = 1'b1;
    bus.l2_hit = 1'b0;
    sb.push_back('{2'b01, 16'h0D0D, '0, 1'b0, 1'b1, c + 5});
    @(negedge clk);
    bus.l2_ack = 1'b0;
    wait_for(2, c);
    bus.req_to_l2 = 2'b00;
    check("timeout_mem_req_dropped", bus.mem_req, 0);
    repeat (2) @(negedge clk);
    check_quiet("post_timeout");
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
